// File: rtl/write_back_stage.sv
// write_back_stage: final pipeline stage. It collects ALU results and load
// responses, aligns and extends load data, and drives the register-file write
// port. Pending loads are tracked in an in-order FIFO, and a per-register busy
// mask reports which destinations are still waiting for load data.
// Optional feature macro: WB_SUBWORD_LOAD_EN enables funct3/offset alignment of
// load data. When it is undefined, every load writes the raw memory word.

package write_back_stage_pkg;
    localparam int unsigned cXLEN       = 32;
    localparam int unsigned cRegNum     = 32;
    localparam int unsigned cRegSelBitW = 5;

    typedef struct packed {
        logic [cRegSelBitW-1:0] addr;
        logic                   dv;
    } tRegOp;
endpackage

module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iAluValid,
    input  logic [cRegSelBitW-1:0] iAluRd,
    input  logic [cXLEN-1:0]       iAluData,
    output logic                   oAluReady,
    input  logic                   iLdIssue,
    input  logic [cRegSelBitW-1:0] iLdRd,
    input  logic [2:0]             iLdFunct3,
    input  logic [1:0]             iLdOffset,
    output logic                   oLdReady,
    input  logic                   iMemValid,
    input  logic [cXLEN-1:0]       iMemData,
    output tRegOp                  rd,
    output logic [cXLEN-1:0]       rdData,
    output logic [cRegNum-1:0]     oBusy,
    output logic                   oLdErr
);

    localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(LD_DEPTH + 1);

    // Pending-load FIFO storage; vld_q marks live entries for the busy mask.
    logic [cRegSelBitW-1:0] fifo_rd_q [LD_DEPTH];
    logic [LD_DEPTH-1:0]    vld_q;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        count_q;

`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0] fifo_f3_q  [LD_DEPTH];
    logic [1:0] fifo_off_q [LD_DEPTH];
`else
    // Alignment inputs have no effect in the full-word-only build.
    logic unused_ld_fields;
    assign unused_ld_fields = ^{iLdFunct3, iLdOffset};
`endif

    logic full, empty, push, pop, ld_err_set;
    logic [cRegSelBitW-1:0] head_rd;
    logic [cXLEN-1:0]       load_data;

    // Write-port registers and sticky error flag.
    tRegOp            rd_q;
    logic [cXLEN-1:0] rd_data_q;
    logic             ld_err_q;

    // Next-state of the write port.
    logic                   wr_en;
    logic [cRegSelBitW-1:0] wr_addr;
    logic [cXLEN-1:0]       wr_data;

`ifdef WB_SUBWORD_LOAD_EN
    function automatic logic [cXLEN-1:0] align_load(input logic [2:0]       f3,
                                                    input logic [1:0]       off,
                                                    input logic [cXLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  align_load = {{(cXLEN-8){b[7]}}, b};
            3'b100:  align_load = {{(cXLEN-8){1'b0}}, b};
            3'b001:  align_load = {{(cXLEN-16){h[15]}}, h};
            3'b101:  align_load = {{(cXLEN-16){1'b0}}, h};
            default: align_load = word;  // LW and undefined codes pass the word
        endcase
    endfunction
`endif

    // FIFO status, push/pop qualification and head decode.
    always_comb begin
        full       = (count_q == CntW'(LD_DEPTH));
        empty      = (count_q == '0);
        oLdReady   = !full;
        push       = iLdIssue && !full;  // no bypass: refused when full even if popping
        pop        = iMemValid && !empty;
        ld_err_set = iMemValid && empty;
        oAluReady  = !iMemValid;
        head_rd    = fifo_rd_q[rd_ptr_q];
`ifdef WB_SUBWORD_LOAD_EN
        load_data  = align_load(fifo_f3_q[rd_ptr_q], fifo_off_q[rd_ptr_q], iMemData);
`else
        load_data  = iMemData;
`endif
    end

    // Write arbitration: a load response always wins over the ALU.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rd_q.addr;
        wr_data = rd_data_q;
        if (pop) begin
            wr_en   = 1'b1;
            wr_addr = head_rd;
            wr_data = load_data;
        end else if (iAluValid && oAluReady) begin
            wr_en   = 1'b1;
            wr_addr = iAluRd;
            wr_data = iAluData;
        end
    end

    // Busy mask: one-hot of every live entry's destination, x0 never busy.
    always_comb begin
        oBusy = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (vld_q[i]) begin
                oBusy[fifo_rd_q[i]] = 1'b1;
            end
        end
        oBusy[0] = 1'b0;
    end

    // FIFO pointers, count, valid bits and entry payload.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (push) begin
                fifo_rd_q[wr_ptr_q] <= iLdRd;
`ifdef WB_SUBWORD_LOAD_EN
                fifo_f3_q[wr_ptr_q]  <= iLdFunct3;
                fifo_off_q[wr_ptr_q] <= iLdOffset;
`endif
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            // Push and pop never hit the same slot: push needs !full, pop needs !empty,
            // and both together only happen with a partially filled FIFO.
            if (pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rd_q      <= '0;
            rd_data_q <= '0;
            ld_err_q  <= 1'b0;
        end else begin
            rd_q.addr <= wr_addr;
            rd_q.dv   <= wr_en && (wr_addr != '0);
            rd_data_q <= wr_data;
            if (ld_err_set) begin
                ld_err_q <= 1'b1;
            end
        end
    end

    assign rd     = rd_q;
    assign rdData = rd_data_q;
    assign oLdErr = ld_err_q;

endmodule

// File: tb/tb_write_back_stage.sv
// Directed self-checking bench for write_back_stage.
module tb_write_back_stage;
    import write_back_stage_pkg::*;

`ifdef WB_SUBWORD_LOAD_EN
    localparam bit Sub = 1'b1;
`else
    localparam bit Sub = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iAluValid;
    logic [4:0]  iAluRd;
    logic [31:0] iAluData;
    logic        oAluReady;
    logic        iLdIssue;
    logic [4:0]  iLdRd;
    logic [2:0]  iLdFunct3;
    logic [1:0]  iLdOffset;
    logic        oLdReady;
    logic        iMemValid;
    logic [31:0] iMemData;
    tRegOp       rd;
    logic [31:0] rdData;
    logic [31:0] oBusy;
    logic        oLdErr;

    int errors = 0;
    int checks = 0;

    write_back_stage #(.LD_DEPTH(4)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iAluValid (iAluValid),
        .iAluRd    (iAluRd),
        .iAluData  (iAluData),
        .oAluReady (oAluReady),
        .iLdIssue  (iLdIssue),
        .iLdRd     (iLdRd),
        .iLdFunct3 (iLdFunct3),
        .iLdOffset (iLdOffset),
        .oLdReady  (oLdReady),
        .iMemValid (iMemValid),
        .iMemData  (iMemData),
        .rd        (rd),
        .rdData    (rdData),
        .oBusy     (oBusy),
        .oLdErr    (oLdErr)
    );

    always #5 iClk = ~iClk;

    task automatic cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        iAluValid = 1'b0;
        iLdIssue  = 1'b0;
        iMemValid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off);
        iLdIssue  = 1'b1;
        iLdRd     = r;
        iLdFunct3 = f3;
        iLdOffset = off;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        cycle();
        cycle();
        iRst = 1'b0;
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0b want 0", rd.dv); end
        checks++; if (rd.addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd.addr); end
        checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rdData); end
        checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", oBusy); end
        checks++; if (oLdErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", oLdErr); end
        checks++; if (oLdReady !== 1'b1) begin errors++; $display("FAIL reset_ldready: got %0b want 1", oLdReady); end
        // Mid-stream: a write in flight and two loads pending, then reset.
        iAluValid = 1'b1; iAluRd = 5'd6; iAluData = 32'hA5A5_A5A5;
        issue(5'd1, 3'b010, 2'd0);
        cycle();
        iAluValid = 1'b0;
        issue(5'd2, 3'b010, 2'd0);
        cycle();
        idle();
        checks++; if (oBusy !== 32'h6) begin errors++; $display("FAIL pend_busy: got %h want 00000006", oBusy); end
        iRst = 1'b1;
        cycle();
        iRst = 1'b0;
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL midrst_dv: got %0b want 0", rd.dv); end
        checks++; if (rdData !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", rdData); end
        checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL midrst_busy: got %h want 0", oBusy); end
        checks++; if (oLdReady !== 1'b1) begin errors++; $display("FAIL midrst_ldready: got %0b want 1", oLdReady); end
        iMemValid = 1'b1; iMemData = 32'h0000_0011;
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL midrst_nowrite: got dv %0b want 0", rd.dv); end
        checks++; if (oLdErr !== 1'b1) begin errors++; $display("FAIL midrst_err: got %0b want 1", oLdErr); end
        iRst = 1'b1;
        cycle();
        iRst = 1'b0;
        checks++; if (oLdErr !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", oLdErr); end
    endtask

    task automatic test_alu();
        iAluValid = 1'b1; iAluRd = 5'd5; iAluData = 32'h1234_5678;
        #1;
        checks++; if (oAluReady !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0b want 1", oAluReady); end
        cycle();
        iAluRd = 5'd31; iAluData = 32'hDEAD_BEEF;
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd5 || rdData !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_write: got dv=%0b addr=%0d data=%h want 1/5/12345678", rd.dv, rd.addr, rdData);
        end
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd31 || rdData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_b2b: got dv=%0b addr=%0d data=%h want 1/31/deadbeef", rd.dv, rd.addr, rdData);
        end
        cycle();
        checks++; if (rd.dv !== 1'b0 || rd.addr !== 5'd31 || rdData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_hold: got dv=%0b addr=%0d data=%h want 0/31/deadbeef", rd.dv, rd.addr, rdData);
        end
    endtask

    task automatic test_subword();
        logic [31:0] exp;
        // LB x7, offset 3
        issue(5'd7, 3'b000, 2'd3);
        cycle();
        idle();
        checks++; if (oBusy !== 32'h80) begin errors++; $display("FAIL lb_busy_rise: got %h want 00000080", oBusy); end
        cycle();
        iMemValid = 1'b1; iMemData = 32'h80FF_0000;
        #1;
        checks++; if (oBusy[7] !== 1'b1) begin errors++; $display("FAIL lb_busy_hold: got %0b want 1", oBusy[7]); end
        cycle();
        idle();
        exp = Sub ? 32'hFFFF_FF80 : 32'h80FF_0000;
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd7 || rdData !== exp) begin
            errors++; $display("FAIL lb_write: got dv=%0b addr=%0d data=%h want 1/7/%h", rd.dv, rd.addr, rdData, exp);
        end
        checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL lb_busy_fall: got %h want 0", oBusy); end
        // LHU x9, offset 2
        issue(5'd9, 3'b101, 2'd2);
        cycle();
        idle();
        iMemValid = 1'b1; iMemData = 32'hBEEF_1234;
        cycle();
        idle();
        exp = Sub ? 32'h0000_BEEF : 32'hBEEF_1234;
        checks++; if (rdData !== exp) begin errors++; $display("FAIL lhu_data: got %h want %h", rdData, exp); end
        // LBU x9, offset 1
        issue(5'd9, 3'b100, 2'd1);
        cycle();
        idle();
        iMemValid = 1'b1; iMemData = 32'h0000_F000;
        cycle();
        idle();
        exp = Sub ? 32'h0000_00F0 : 32'h0000_F000;
        checks++; if (rdData !== exp) begin errors++; $display("FAIL lbu_data: got %h want %h", rdData, exp); end
        // LH x9, offset 0
        issue(5'd9, 3'b001, 2'd0);
        cycle();
        idle();
        iMemValid = 1'b1; iMemData = 32'h1234_8001;
        cycle();
        idle();
        exp = Sub ? 32'hFFFF_8001 : 32'h1234_8001;
        checks++; if (rdData !== exp) begin errors++; $display("FAIL lh_data: got %h want %h", rdData, exp); end
    endtask

    task automatic test_collision();
        issue(5'd4, 3'b010, 2'd0);
        cycle();
        idle();
        iAluValid = 1'b1; iAluRd = 5'd3; iAluData = 32'h3333_3333;
        iMemValid = 1'b1; iMemData = 32'h4444_4444;
        #1;
        checks++; if (oAluReady !== 1'b0) begin errors++; $display("FAIL coll_ready: got %0b want 0", oAluReady); end
        cycle();
        iMemValid = 1'b0;
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd4 || rdData !== 32'h4444_4444) begin
            errors++; $display("FAIL coll_load: got dv=%0b addr=%0d data=%h want 1/4/44444444", rd.dv, rd.addr, rdData);
        end
        #1;
        checks++; if (oAluReady !== 1'b1) begin errors++; $display("FAIL coll_ready2: got %0b want 1", oAluReady); end
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd3 || rdData !== 32'h3333_3333) begin
            errors++; $display("FAIL coll_alu: got dv=%0b addr=%0d data=%h want 1/3/33333333", rd.dv, rd.addr, rdData);
        end
        cycle();
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL coll_once: got dv %0b want 0", rd.dv); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            issue(5'(10 + i), 3'b010, 2'd0);
            cycle();
        end
        issue(5'd14, 3'b010, 2'd0);
        checks++; if (oLdReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", oLdReady); end
        checks++; if (oBusy !== 32'h3C00) begin errors++; $display("FAIL full_busy: got %h want 00003c00", oBusy); end
        cycle();
        checks++; if (oBusy !== 32'h3C00) begin errors++; $display("FAIL full_refuse: got %h want 00003c00", oBusy); end
        // Pop while full: the same-cycle push of x14 is still refused.
        iMemValid = 1'b1; iMemData = 32'h0000_1000;
        cycle();
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd10 || rdData !== 32'h0000_1000) begin
            errors++; $display("FAIL pop0: got dv=%0b addr=%0d data=%h want 1/10/00001000", rd.dv, rd.addr, rdData);
        end
        checks++; if (oBusy !== 32'h3800) begin errors++; $display("FAIL nobypass_busy: got %h want 00003800", oBusy); end
        // Push and pop together when not full.
        issue(5'd15, 3'b010, 2'd0);
        iMemData = 32'h0000_1001;
        cycle();
        iLdIssue = 1'b0;
        checks++; if (rd.addr !== 5'd11 || rdData !== 32'h0000_1001) begin
            errors++; $display("FAIL pop1: got addr=%0d data=%h want 11/00001001", rd.addr, rdData);
        end
        checks++; if (oBusy !== 32'hB000) begin errors++; $display("FAIL pushpop_busy: got %h want 0000b000", oBusy); end
        checks++; if (oLdReady !== 1'b1) begin errors++; $display("FAIL pushpop_ready: got %0b want 1", oLdReady); end
        iMemData = 32'h0000_1002;
        cycle();
        checks++; if (rd.addr !== 5'd12) begin errors++; $display("FAIL pop2: got addr=%0d want 12", rd.addr); end
        iMemData = 32'h0000_1003;
        cycle();
        checks++; if (rd.addr !== 5'd13 || rdData !== 32'h0000_1003) begin
            errors++; $display("FAIL pop3: got addr=%0d data=%h want 13/00001003", rd.addr, rdData);
        end
        iMemData = 32'h0000_1004;
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b1 || rd.addr !== 5'd15) begin
            errors++; $display("FAIL pop4: got dv=%0b addr=%0d want 1/15", rd.dv, rd.addr);
        end
        checks++; if (oBusy !== 32'h0 || oLdErr !== 1'b0 || oLdReady !== 1'b1) begin
            errors++; $display("FAIL drained: got busy=%h err=%0b ready=%0b want 0/0/1", oBusy, oLdErr, oLdReady);
        end
    endtask

    task automatic test_x0_and_err();
        iAluValid = 1'b1; iAluRd = 5'd0; iAluData = 32'h0000_0055;
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL x0_alu: got dv %0b want 0", rd.dv); end
        issue(5'd0, 3'b010, 2'd0);
        cycle();
        idle();
        checks++; if (oBusy !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h want 0", oBusy); end
        iMemValid = 1'b1; iMemData = 32'h0000_0077;
        cycle();
        idle();
        checks++; if (rd.dv !== 1'b0) begin errors++; $display("FAIL x0_load: got dv %0b want 0", rd.dv); end
        checks++; if (oLdErr !== 1'b0) begin errors++; $display("FAIL x0_popped: got err %0b want 0", oLdErr); end
        iMemValid = 1'b1; iMemData = 32'h0000_0088;
        cycle();
        idle();
        checks++; if (oLdErr !== 1'b1 || rd.dv !== 1'b0) begin
            errors++; $display("FAIL empty_resp: got err=%0b dv=%0b want 1/0", oLdErr, rd.dv);
        end
        cycle();
        cycle();
        cycle();
        checks++; if (oLdErr !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", oLdErr); end
    endtask

    initial begin
        iRst = 1'b1;
        iAluRd = '0; iAluData = '0;
        iLdRd = '0; iLdFunct3 = '0; iLdOffset = '0; iMemData = '0;
        idle();
        test_reset();
        test_alu();
        test_subword();
        test_collision();
        test_fifo_full();
        test_x0_and_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
